// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, opcode map, the fetch-stage NOP and the
// fetch FSM state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 6;
  localparam int CPU_INSTR_W = 10;
  localparam int CPU_DATA_W  = 8;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_BR    = 4'd4,
    OP_BL    = 4'd5,
    OP_BXLR  = 4'd6
  } opcode_e;

  // Undefined opcode; the control FSM stays idle while it sees this.
  localparam logic [3:0]             OP_NOP = 4'b1111;
  localparam logic [CPU_INSTR_W-1:0] NOP    = {OP_NOP, 6'b000_000};

  typedef enum logic [1:0] {
    F_REQ   = 2'd0,
    F_CAP   = 2'd1,
    F_READY = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: program counter, synchronous-ROM fetch FSM and link-value
// bus driver.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W,
  parameter int DATA_W  = CPU_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  br_add,
  input  logic               bxlr,
  input  logic [DATA_W-1:0]  bus_in,
  input  logic               pc_tri,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  pc_bus_out,
  output logic               pc_bus_oe
);

  localparam logic [INSTR_W-1:0] NOP_W = {OP_NOP, {(INSTR_W-4){1'b0}}};

  fetch_state_e        state, state_nxt;
  logic [ADDR_W-1:0]   pc_nxt, pc_inc;
  logic [INSTR_W-1:0]  instr_q;
  logic                redir_d, pc_upd;
  logic                unused_bus_hi;

  assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];

  assign pc_inc = pc + ADDR_W'(1);
  // A done right after a redirect belongs to the old stream and is dropped.
  assign pc_upd = bxlr | branch | (done & ~redir_d);

  always_comb begin
    pc_nxt = pc;
    if (bxlr)                pc_nxt = bus_in[ADDR_W-1:0];
    else if (branch)         pc_nxt = br_add;
    else if (done && !redir_d) pc_nxt = pc_inc;
  end

  always_comb begin
    state_nxt = state;
    if (pc_upd) state_nxt = F_REQ;
    else begin
      case (state)
        F_REQ:   state_nxt = F_CAP;
        F_CAP:   state_nxt = F_READY;
        default: state_nxt = F_READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      state   <= F_REQ;
      redir_d <= 1'b0;
      instr_q <= NOP_W;
    end else begin
      pc      <= pc_nxt;
      state   <= state_nxt;
      redir_d <= bxlr | branch;
      // Capture only when the fetch survives this cycle.
      if (state == F_CAP && !pc_upd) instr_q <= rom_data;
    end
  end

  assign rom_addr    = pc;
  assign instr_valid = (state == F_READY);
  assign instruction = (state == F_READY) ? instr_q : NOP_W;
  assign pc_bus_oe   = pc_tri;
  assign pc_bus_out  = pc_tri ? DATA_W'(pc_inc) : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations, then randomized traffic against a fetch-age reference model.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam logic [9:0] NOP_I = 10'b1111_000_000;

  logic       clk, rst, done, branch, bxlr, pc_tri;
  logic [5:0] br_add, rom_addr, pc;
  logic [7:0] bus_in, pc_bus_out;
  logic [9:0] rom_data, instruction;
  logic       instr_valid, pc_bus_oe;

  logic [9:0] rom [64];
  int n_checks = 0, n_err = 0;
  bit chk_en = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .done(done), .branch(branch), .br_add(br_add),
    .bxlr(bxlr), .bus_in(bus_in), .pc_tri(pc_tri), .rom_addr(rom_addr),
    .rom_data(rom_data), .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_bus_out(pc_bus_out), .pc_bus_oe(pc_bus_oe)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // External synchronous ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Reference model: PC plus number of edges since the PC last changed.
  // The fetched word is presented once two edges have passed.
  logic [5:0] m_pc;
  int         m_age;
  logic       m_redir;
  logic       m_upd;
  assign m_upd = bxlr | branch | (done & ~m_redir);

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 6'd0; m_age <= 0; m_redir <= 1'b0;
    end else begin
      m_redir <= bxlr | branch;
      if (bxlr)        m_pc <= bus_in[5:0];
      else if (branch) m_pc <= br_add;
      else if (m_upd)  m_pc <= m_pc + 6'd1;
      m_age <= m_upd ? 0 : ((m_age < 2) ? m_age + 1 : 2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      logic       ev;
      logic [5:0] ret;
      ev  = (m_age >= 2);
      ret = m_pc + 6'd1;
      chk("m_pc",        32'(pc),          32'(m_pc));
      chk("m_rom_addr",  32'(rom_addr),    32'(m_pc));
      chk("m_valid",     32'(instr_valid), 32'(ev));
      chk("m_instr",     32'(instruction), 32'(ev ? rom[m_pc] : NOP_I));
      chk("m_oe",        32'(pc_bus_oe),   32'(pc_tri));
      chk("m_bus_out",   32'(pc_bus_out),  32'(pc_tri ? {2'b00, ret} : 8'h00));
    end
  end

  task automatic edge_();
    @(posedge clk); #2;
  endtask

  task automatic idle();
    done = 0; branch = 0; bxlr = 0; pc_tri = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 10'($urandom);
    rom[0] = 10'h0A5; rom[5] = 10'h055; rom[7] = 10'h377;
    rom[20] = 10'h214; rom[44] = 10'h2C2;
    rst = 1; idle(); br_add = 0; bus_in = 0;

    // Reset overrides simultaneous requests
    edge_(); chk_en = 1;
    done = 1; branch = 1; bxlr = 1; br_add = 6'd9; bus_in = 8'h11;
    edge_(); idle();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instruction), 32'(NOP_I));
    edge_();
    rst = 0;
    // Reset then idle: NOP for 2 cycles, then ROM[0]
    chk("boot_nop0", 32'(instruction), 32'(NOP_I));
    edge_(); chk("boot_nop1", 32'(instruction), 32'(NOP_I));
    edge_();
    chk("boot_instr", 32'(instruction), 32'h0A5);
    chk("boot_valid", 32'(instr_valid), 32'd1);
    chk("boot_pc", 32'(pc), 32'd0);

    // Wrap 63 -> 0
    branch = 1; br_add = 6'd63; edge_(); idle(); edge_(); edge_();
    chk("wrap_pre_pc", 32'(pc), 32'd63);
    chk("wrap_pre_valid", 32'(instr_valid), 32'd1);
    done = 1; edge_(); idle();
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_valid0", 32'(instr_valid), 32'd0);
    edge_(); edge_();
    chk("wrap_instr", 32'(instruction), 32'h0A5);

    // Done right after branch is absorbed
    branch = 1; br_add = 6'd20; edge_(); idle();
    done = 1; edge_(); idle();
    chk("absorb_pc", 32'(pc), 32'd20);
    edge_();
    chk("absorb_instr", 32'(instruction), 32'h214);
    chk("absorb_valid", 32'(instr_valid), 32'd1);

    // Branch and done together
    branch = 1; done = 1; br_add = 6'd5; edge_(); idle();
    chk("brdone_pc", 32'(pc), 32'd5);
    edge_(); edge_();
    chk("brdone_pc2", 32'(pc), 32'd5);
    chk("brdone_instr", 32'(instruction), 32'h055);

    // Return address on the bus
    branch = 1; br_add = 6'd9; edge_(); idle();
    pc_tri = 1; #1;
    chk("link_oe", 32'(pc_bus_oe), 32'd1);
    chk("link_out", 32'(pc_bus_out), 32'h0A);
    pc_tri = 0; #1;
    chk("link_off", 32'(pc_bus_out), 32'h00);

    // bxlr wins over branch
    bxlr = 1; branch = 1; bus_in = 8'h2C; br_add = 6'd3; edge_(); idle();
    bus_in = 8'hFF;
    chk("bxlr_pc", 32'(pc), 32'd44);
    edge_(); edge_();
    chk("bxlr_instr", 32'(instruction), 32'h2C2);

    // Reset during CAP drops the in-flight ROM[7]
    branch = 1; br_add = 6'd7; edge_(); idle();
    edge_();
    rst = 1; edge_(); rst = 0;
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_instr", 32'(instruction), 32'(NOP_I));
    pc_tri = 1; #1;
    chk("midrst_link", 32'(pc_bus_out), 32'h01);
    pc_tri = 0;
    edge_(); chk("midrst_nop", 32'(instruction), 32'(NOP_I));
    edge_(); chk("midrst_instr0", 32'(instruction), 32'h0A5);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 99) == 0);
      bxlr   = ($urandom_range(0, 15) == 0);
      branch = ($urandom_range(0, 7) == 0);
      done   = ($urandom_range(0, 3) == 0);
      pc_tri = $urandom_range(0, 1);
      br_add = 6'($urandom);
      bus_in = 8'($urandom);
      edge_();
    end
    rst = 0; idle();
    edge_(); edge_();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters: ADDR_W, default 6, program-counter and ROM address width; INSTR_W, default 10, instruction width (4-bit opcode + two 3-bit args); DATA_W, default 8, datapath bus width.
REQ-002 Ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- done  in  1  current instruction retired; advance PC.
- branch  in  1  redirect PC to br_add.
- br_add  in  ADDR_W  branch target.
- bxlr  in  1  redirect PC to bus_in[ADDR_W-1:0].
- bus_in  in  DATA_W  datapath bus value (link register contents during bxlr).
- pc_tri  in  1  request to drive saved PC onto bus.
- rom_addr  out  ADDR_W  synchronous ROM address.
- rom_data  in  INSTR_W  ROM read data, valid one cycle after rom_addr.
- instruction  out  INSTR_W  instruction presented to the control FSM.
- instr_valid  out  1  instruction holds a fetched word.
- pc  out  ADDR_W  current program counter.
- pc_bus_out  out  DATA_W  link value for the bus.
- pc_bus_oe  out  1  drive enable for pc_bus_out.

Function
REQ-003 rom_addr SHALL equal pc combinationally at all times.
REQ-004 The FSM SHALL have three states: REQ (ROM addressed), CAP (capture rom_data), READY (instruction valid).
REQ-005 Transitions: REQ->CAP unconditionally; CAP->READY unconditionally; READY->REQ on any PC update; otherwise hold.
REQ-006 On the CAP edge, instruction SHALL load rom_data; instr_valid SHALL be 1 only in READY.
REQ-007 Outside READY, instruction SHALL read NOP = 4'b1111 opcode with zero args (10'b1111_000_000), an undefined opcode that keeps the control FSM idle.
REQ-008 Fetch latency: an instruction is valid 2 cycles after the edge that updates pc.
REQ-009 PC update priority, evaluated every cycle: bxlr -> pc <= bus_in[ADDR_W-1:0]; else branch -> pc <= br_add; else done (not absorbed) -> pc <= pc+1.
REQ-010 Increment SHALL wrap modulo 2^ADDR_W: 63 -> 0.
REQ-011 A redirect (branch or bxlr) SHALL set a one-cycle register redir_d; a done in the cycle where redir_d=1 SHALL be absorbed (no increment).
REQ-012 branch and done asserted in the same cycle SHALL load br_add, and done SHALL NOT increment.
REQ-013 A redirect in any state SHALL take effect immediately and restart the fetch in REQ; an in-flight CAP capture SHALL be discarded.
REQ-014 A non-absorbed done received in REQ or CAP SHALL increment pc and restart from REQ.
REQ-015 pc_bus_oe SHALL equal pc_tri.
REQ-016 pc_bus_out SHALL equal zero-extended (pc+1) mod 2^ADDR_W, the return address, whenever pc_tri=1, and 0 otherwise.
REQ-017 bus_in SHALL be ignored unless bxlr=1.

Reset
REQ-018 When rst=1 at a clock edge: pc=0, state=REQ, instruction=NOP, instr_valid=0, redir_d=0.
REQ-019 rst SHALL override every simultaneous done, branch or bxlr.
REQ-020 rst asserted mid-fetch SHALL abandon that fetch. The first valid instruction, from address 0, SHALL appear 2 cycles after rst deasserts.
REQ-021 pc_bus_oe is combinational from pc_tri and is therefore unaffected by reset. During reset pc_bus_out SHALL reflect pc=0 (value 1) if pc_tri=1.

Structure
REQ-022 A shared package cpu_pkg SHALL hold: the ADDR_W, INSTR_W and DATA_W defaults; the opcode constants (LOAD=0 through BXLR=6); the NOP constant; and the fetch state encoding.
REQ-023 The block SHALL be a single module. The ROM is external and SHALL NOT be a sub-module.

Verification
REQ-024 Reset then idle, ROM[0]=10'h0A5 -> instruction=NOP for 2 cycles, then 10'h0A5 with instr_valid=1 and pc=0.
REQ-025 pc=63 in READY, done pulse -> pc=0; ROM[0] word valid 2 cycles later.
REQ-026 branch=1 with br_add=6'd20, then done the next cycle -> pc=20, not 21; ROM[20] presented.
REQ-027 branch and done in the same cycle with br_add=6'd5 -> pc=5 and no extra increment. pc_tri=1 with pc=9 -> pc_bus_oe=1, pc_bus_out=8'd10.
REQ-028 bxlr=1 with branch=1, bus_in=8'h2C, br_add=6'd3 -> pc=6'd44 (bxlr wins).
REQ-029 rst asserted during CAP with ROM[7] in flight -> instruction stays NOP, pc=0; the ROM[7] word never appears.
